// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for pipeline-stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t;
  localparam int REGWRITE_BIT = 0;
  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load enable and synchronous clear
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline-stage register with two-entry skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int DATA_CH  = 2,
  parameter int CTRL_W   = 2,
  parameter int RD_W     = REG_IDX_W,
  parameter int KILL_RD0 = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [DATA_CH*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]           in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [DATA_CH*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]           out_rd,
  output logic [1:0]                occupancy
);
  localparam int DW = DATA_CH * DATA_W;
  localparam int W = CTRL_W + DW + RD_W;
  pipe_state_t state, state_n;
  logic in_fire, out_fire, main_load, skid_load;
  logic [CTRL_W-1:0] kill_mask;
  logic [W-1:0] cap, main_d, main_q, skid_q;
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else state <= state_n;
  end
  always_comb begin
    in_ready  = state != SKID;
    out_valid = state != EMPTY;
    occupancy = state == EMPTY ? 2'd0 : state == FULL ? 2'd1 : 2'd2;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    kill_mask = (KILL_RD0 != 0 && in_rd == '0) ? (CTRL_W'(1) << REGWRITE_BIT) : '0;
    cap       = {in_ctrl & ~kill_mask, in_data, in_rd};
    main_load = !flush && (state == SKID ? out_fire : state == FULL ? in_fire && out_fire : in_fire);
    skid_load = !flush && state == FULL && in_fire && !out_fire;
    main_d    = state == SKID ? skid_q : cap;
    state_n   = state;
    if (flush) state_n = EMPTY;
    else if (state == EMPTY) state_n = in_fire ? FULL : EMPTY;
    else if (state == FULL) state_n = (in_fire && !out_fire) ? SKID : (!in_fire && out_fire) ? EMPTY : FULL;
    else state_n = out_fire ? FULL : SKID;
    out_ctrl = out_valid ? main_q[W-1 -: CTRL_W] : '0;
    out_data = main_q[RD_W +: DW];
    out_rd   = main_q[RD_W-1:0];
  end
  pipe_slot #(.W(W)) u_main (.clk(clk), .clr(reset), .load(main_load), .d(main_d), .q(main_q));
  pipe_slot #(.W(W)) u_skid (.clk(clk), .clr(reset), .load(skid_load), .d(cap), .q(skid_q));
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed plus randomized checks against a FIFO reference model
module tb_pipe_stage_reg;
  typedef struct {
    logic [1:0]  ctrl;
    logic [63:0] data;
    logic [4:0]  rd;
  } ent_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] in_ctrl = 0, out_ctrl, occupancy;
  logic [63:0] in_data = 0, out_data;
  logic [4:0] in_rd = 0, out_rd;
  ent_t q[$];
  bit was_reset;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(32), .DATA_CH(2), .CTRL_W(2), .RD_W(5), .KILL_RD0(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
    .occupancy(occupancy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare();
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("out_ctrl", 64'(out_ctrl), q.size() != 0 ? 64'(q[0].ctrl) : 64'd0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_rd", 64'(out_rd), 64'(q[0].rd));
    end else if (was_reset) begin
      check("reset_data", out_data, 64'd0);
      check("reset_rd", 64'(out_rd), 64'd0);
    end
  endtask
  task automatic step(input logic iv, input logic [1:0] c, input logic [63:0] d, input logic [4:0] r,
                      input logic ordy, input logic fl, input logic rs);
    ent_t e;
    bit inf, outf;
    in_valid = iv; in_ctrl = c; in_data = d; in_rd = r; out_ready = ordy; flush = fl; reset = rs;
    inf = iv && q.size() < 2;
    outf = q.size() != 0 && ordy;
    e.ctrl = r == 0 ? (c & 2'b10) : c;
    e.data = d;
    e.rd = r;
    @(posedge clk);
    if (rs) begin
      q.delete();
      was_reset = 1;
    end else if (fl) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) begin
        q.push_back(e);
        was_reset = 0;
      end
    end
    #1 compare();
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 2'b11, {32'hDEADBEEF, 32'h12345678}, 5'd7, 1, 0, 0);
    check("first_data", out_data, {32'hDEADBEEF, 32'h12345678});
    for (int i = 0; i < 8; i++)
      step(1, 2'(i), {32'(i), $urandom()}, 5'(i + 1), 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 2'b01, 64'h1111, 5'd1, 0, 0, 0);
    step(1, 2'b10, 64'h2222, 5'd2, 0, 0, 0);
    check("bp_occ", 64'(occupancy), 64'd2);
    step(1, 2'b11, 64'h3333, 5'd3, 0, 0, 0);
    step(1, 2'b11, 64'h3333, 5'd3, 1, 0, 0);
    check("bp_head2", out_data, 64'h2222);
    step(1, 2'b11, 64'h3333, 5'd3, 1, 0, 0);
    check("bp_head3", out_data, 64'h3333);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 2'b01, 64'h4444, 5'd4, 0, 0, 0);
    step(1, 2'b01, 64'h5555, 5'd5, 0, 0, 0);
    step(1, 2'b11, 64'h6666, 5'd6, 0, 1, 0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 2'b11, 64'h7777, 5'd0, 1, 0, 0);
    check("kill_rd0", 64'(out_ctrl), 64'(2'b10));
    step(1, 2'b11, 64'h8888, 5'd3, 1, 0, 0);
    check("keep_rd3", 64'(out_ctrl), 64'(2'b11));
    step(1, 2'b11, 64'h9999, 5'd9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_data", out_data, 64'd0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom()), {$urandom(), $urandom()},
           5'($urandom_range(0, 3) == 0 ? 0 : $urandom()), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
